axo_mem_arbiter: RTL and testbench
==================================

Name: axo_mem_arbiter

Overview:
- Two-master, one-slave memory arbiter that lets the Axolotl³² core's instruction-fetch port and data port share a single memory bus.
- Serialises accesses using round-robin priority and holds each grant until the slave completes.
- Checks address alignment before issuing, and aborts stalled accesses with a watchdog timeout.
- Sits between the core's fetch/data ports and the unified SRAM/peripheral bus. It uses split read/write data buses, so there is no inout inside the block.

Parameters:
- XLEN, 32, address/data width.
- TIMEOUT, 255, maximum cycles a granted access may wait for bus_ready; 0 disables the watchdog.
- TW, 8, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- i_re  in  1  fetch request; held stable until i_ready.
- i_addr  in  XLEN  fetch address.
- i_rdata  out  XLEN  fetch data, valid while i_ready.
- i_ready  out  1  fetch complete (one cycle).
- i_err  out  1  fetch fault, qualified by i_ready.
- d_re  in  1  data read request.
- d_we  in  1  data write request.
- d_asize  in  2  access size, 2^n bytes.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  write data.
- d_rdata  out  XLEN  read data, valid while d_ready.
- d_ready  out  1  data access complete (one cycle).
- d_err  out  1  data fault, qualified by d_ready.
- bus_re  out  1  slave read.
- bus_we  out  1  slave write.
- bus_asize  out  2  slave access size.
- bus_addr  out  XLEN  slave address.
- bus_wdata  out  XLEN  slave write data.
- bus_rdata  in  XLEN  slave read data.
- bus_ready  in  1  slave completion.

Behaviour:
- States: IDLE, GNT_I, GNT_D, FAULT.
- Registers: state, last_grant (I/D), fault_src (I/D), tcnt[TW-1:0].

Reset:
- state=IDLE, last_grant=I (so data wins the first tie), tcnt=0.
- All outputs 0; rdata outputs 0 outside a granted access.

IDLE:
- Bus outputs are 0.
- Data requester active (d_re|d_we):
  - d_re&d_we together → FAULT(D).
  - d_asize=3 → FAULT(D).
  - Misaligned (asize=1 with addr[0]; asize=2 with addr[1:0]≠0) → FAULT(D).
- Fetch requester active with i_addr[1:0]≠0 → FAULT(I).
- Both masters requesting a legal access → grant the one that is not last_grant.
- Single legal request → grant it.
- Legality is evaluated only for the winning requester.
- Any transition to GNT_x clears tcnt.
- The minimum access takes 2 cycles: grant at edge N+1, completion no earlier than cycle N+1.

GNT_I / GNT_D:
- bus_* is driven combinationally from the granted master. Fetch drives bus_asize=2 and bus_we=0.
- x_rdata = bus_rdata, and x_ready = bus_ready, combinationally.
- bus_ready=1 → at the next edge: last_grant=x, state=IDLE.
- Requester drops its request before bus_ready → abort at the next edge:
  - bus_* goes 0 combinationally in that cycle;
  - no ready is returned;
  - state returns to IDLE and last_grant is unchanged.
- Otherwise tcnt increments each cycle.
- TIMEOUT≠0 and tcnt==TIMEOUT-1 without bus_ready → FAULT(x) at the next edge.

FAULT:
- Lasts exactly one cycle.
- The source master gets x_ready=1 and x_err=1; bus_* stays 0.
- Next state: IDLE. last_grant is set to fault_src so the other master gets priority afterwards.

Simultaneous events:
- bus_ready arriving in the same cycle as the timeout threshold → completion wins, no error.
- A request that stays high after its ready is treated as a new request in IDLE.
- The non-granted master is never given ready.

Reset mid-access:
- Bus strobes drop immediately (asynchronous reset).
- No ready or err is returned.

Decomposition:
- In axo_base.v: `AXO_ARB_IDLE/GNT_I/GNT_D/FAULT state encodings, and `AXO_ASIZE_B/H/W/RSVD (0..3).
- Sub-module axo_rr_arb2: combinational 2-way round-robin pick from (req_i, req_d, last_grant) → grant_i/grant_d.
- The alignment check stays inline.

Test Plan:
- Lone fetch, i_addr=0x100, bus_ready one cycle after bus_re, bus_rdata=0x00000013 → bus_re/addr=0x100/asize=2; i_ready=1 with i_rdata=0x13 in the same cycle; then IDLE.
- d_re and i_re asserted together from reset → data granted first; after its bus_ready, fetch is granted next; the pair repeats alternating D, I, D, I.
- d_we, asize=1, addr=0x203 → FAULT: d_ready=d_err=1 for one cycle; bus_we never asserted.
- TIMEOUT=4, bus_ready held 0 → bus_re high for 4 cycles; then the requester gets ready=err=1; then IDLE with bus idle.
- d_re dropped 2 cycles into a grant → bus_re falls the same cycle; no d_ready; a pending fetch is granted next.
- rst pulsed while in GNT_D → all bus strobes 0 immediately; state IDLE; last_grant=I.

Source files
------------

// File: rtl/axo_mem_arbiter_pkg.sv
// axo_mem_arbiter_pkg: shared state/source encodings and alignment helper for the memory arbiter
package axo_mem_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D, ARB_FAULT} arb_state_t;
  typedef enum logic {SRC_I, SRC_D} src_t;
  localparam logic [1:0] ASIZE_B = 2'd0;
  localparam logic [1:0] ASIZE_H = 2'd1;
  localparam logic [1:0] ASIZE_W = 2'd2;
  localparam logic [1:0] ASIZE_RSVD = 2'd3;
  function automatic logic bad_align(input logic [1:0] asize, input logic [1:0] lsb);
    return asize != ASIZE_B && (asize == ASIZE_RSVD || (asize == ASIZE_H && lsb[0]) || (asize == ASIZE_W && |lsb));
  endfunction
endpackage

// File: rtl/axo_mem_arbiter_rr.sv
// axo_mem_arbiter_rr: combinational two-way round-robin pick favouring the master not granted last
module axo_mem_arbiter_rr
  import axo_mem_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  src_t last_grant,
  output logic grant_i,
  output logic grant_d
);
  always_comb begin
    grant_d = req_d && (!req_i || last_grant == SRC_I);
    grant_i = req_i && !grant_d;
  end
endmodule

// File: rtl/axo_mem_arbiter.sv
// axo_mem_arbiter: shares one memory bus between fetch and data ports with round-robin, alignment faults and a watchdog
module axo_mem_arbiter
  import axo_mem_arbiter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TIMEOUT = 255,
  parameter int TW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_re,
  input  logic [XLEN-1:0] i_addr,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_ready,
  output logic            i_err,
  input  logic            d_re,
  input  logic            d_we,
  input  logic [1:0]      d_asize,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ready,
  output logic            d_err,
  output logic            bus_re,
  output logic            bus_we,
  output logic [1:0]      bus_asize,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_ready
);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  arb_state_t state;
  src_t last_grant, fault_src, gsrc;
  logic [TW-1:0] tcnt;
  logic d_req, grant_i, grant_d, act, done, expire, d_fault, i_fault, flt_i, flt_d;
  assign d_req = d_re | d_we;
  axo_mem_arbiter_rr u_rr (
    .req_i(i_re),
    .req_d(d_req),
    .last_grant(last_grant),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );
  // act drops the moment the granted requester withdraws, which silences the bus in that same cycle
  always_comb begin
    gsrc = state == ARB_GNT_D ? SRC_D : SRC_I;
    act = (state == ARB_GNT_I && i_re) || (state == ARB_GNT_D && d_req);
    done = act && bus_ready;
    expire = act && !bus_ready && TIMEOUT != 0 && tcnt == TLIM;
    d_fault = (d_re && d_we) || bad_align(d_asize, d_addr[1:0]);
    i_fault = |i_addr[1:0];
    flt_i = state == ARB_FAULT && fault_src == SRC_I;
    flt_d = state == ARB_FAULT && fault_src == SRC_D;
  end
  always_comb begin
    bus_re = act && (state == ARB_GNT_I || d_re);
    bus_we = act && state == ARB_GNT_D && d_we;
    bus_asize = !act ? 2'd0 : state == ARB_GNT_I ? ASIZE_W : d_asize;
    bus_addr = !act ? '0 : state == ARB_GNT_I ? i_addr : d_addr;
    bus_wdata = act && state == ARB_GNT_D ? d_wdata : '0;
    i_ready = (state == ARB_GNT_I && done) || flt_i;
    d_ready = (state == ARB_GNT_D && done) || flt_d;
    i_err = flt_i;
    d_err = flt_d;
    i_rdata = state == ARB_GNT_I ? bus_rdata : '0;
    d_rdata = state == ARB_GNT_D ? bus_rdata : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      last_grant <= SRC_I;
      fault_src <= SRC_I;
      tcnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          tcnt <= '0;
          if (grant_d) begin
            state <= d_fault ? ARB_FAULT : ARB_GNT_D;
            fault_src <= SRC_D;
          end else if (grant_i) begin
            state <= i_fault ? ARB_FAULT : ARB_GNT_I;
            fault_src <= SRC_I;
          end
        end
        ARB_FAULT: begin
          state <= ARB_IDLE;
          last_grant <= fault_src;
        end
        default: begin
          if (!act) state <= ARB_IDLE;
          else if (done) begin
            state <= ARB_IDLE;
            last_grant <= gsrc;
          end else if (expire) begin
            state <= ARB_FAULT;
            fault_src <= gsrc;
          end else tcnt <= tcnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axo_mem_arbiter.sv
// tb_axo_mem_arbiter: directed scenarios plus randomized transactions checked against a transaction-level model
module tb_axo_mem_arbiter;
  localparam int TO = 4;
  logic clk, rst;
  logic i_re, i_ready, i_err, d_re, d_we, d_ready, d_err;
  logic bus_re, bus_we, bus_ready;
  logic [1:0] d_asize, bus_asize;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, bus_addr, bus_wdata, bus_rdata;
  int tests, fails;

  axo_mem_arbiter #(.XLEN(32), .TIMEOUT(TO), .TW(8)) dut (
    .clk(clk), .rst(rst),
    .i_re(i_re), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_err(i_err),
    .d_re(d_re), .d_we(d_we), .d_asize(d_asize), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
    .bus_re(bus_re), .bus_we(bus_we), .bus_asize(bus_asize), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    i_re = 0; i_addr = 0; d_re = 0; d_we = 0; d_asize = 0; d_addr = 0; d_wdata = 0;
    bus_ready = 0; bus_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    #1;
    tests++;
    if ({i_ready, i_err, d_ready, d_err, bus_re, bus_we, bus_asize, bus_addr, bus_wdata, i_rdata, d_rdata} !== '0) begin
      fails++; $display("FAIL reset_outputs: got nonzero outputs bus_re=%b i_ready=%b d_ready=%b", bus_re, i_ready, d_ready);
    end
    @(negedge clk);
    i_re = 1; d_re = 1; d_asize = 2; bus_ready = 1; bus_rdata = 32'hdeadbeef;
    @(posedge clk);
    #1;
    tests++;
    if ({bus_re, bus_we, i_ready, d_ready, i_rdata, d_rdata} !== '0) begin
      fails++; $display("FAIL reset_held: got bus_re=%b i_ready=%b d_ready=%b want all 0", bus_re, i_ready, d_ready);
    end
    @(negedge clk);
    idle_inputs();
    rst = 0;
  endtask

  task automatic test_lone_fetch();
    @(negedge clk);
    i_re = 1; i_addr = 32'h100;
    #1;
    tests++;
    if (bus_re !== 0) begin fails++; $display("FAIL fetch_idle: got bus_re=%b want 0", bus_re); end
    @(negedge clk);
    #1;
    tests++;
    if ({bus_re, bus_we, bus_asize, bus_addr, i_ready} !== {1'b1, 1'b0, 2'd2, 32'h100, 1'b0}) begin
      fails++; $display("FAIL fetch_grant: got re=%b we=%b asize=%0d addr=%h rdy=%b", bus_re, bus_we, bus_asize, bus_addr, i_ready);
    end
    @(negedge clk);
    bus_ready = 1; bus_rdata = 32'h13;
    #1;
    tests++;
    if ({i_ready, i_err, i_rdata, d_ready} !== {1'b1, 1'b0, 32'h13, 1'b0}) begin
      fails++; $display("FAIL fetch_done: got rdy=%b err=%b rdata=%h want 1 0 00000013", i_ready, i_err, i_rdata);
    end
    @(negedge clk);
    i_re = 0; bus_ready = 0;
    #1;
    tests++;
    if ({bus_re, i_ready, i_rdata} !== '0) begin
      fails++; $display("FAIL fetch_after: got bus_re=%b rdy=%b rdata=%h want 0", bus_re, i_ready, i_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    do_reset();
    @(negedge clk);
    d_re = 1; d_asize = 2; d_addr = 32'h400; i_re = 1; i_addr = 32'h800; bus_ready = 1; bus_rdata = 32'h55;
    for (int k = 0; k < 8; k++) begin
      #1;
      want = (k % 4 == 1) ? 32'h400 : 32'h800;
      tests++;
      if (k % 2 == 0 && bus_re !== 0) begin
        fails++; $display("FAIL alt_idle[%0d]: got bus_re=%b want 0", k, bus_re);
      end else if (k % 2 == 1 && {bus_re, bus_addr, d_ready, i_ready} !== {1'b1, want, want == 32'h400, want == 32'h800}) begin
        fails++; $display("FAIL alt_grant[%0d]: got addr=%h d_rdy=%b i_rdy=%b want addr=%h", k, bus_addr, d_ready, i_ready, want);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_fault();
    @(negedge clk);
    d_we = 1; d_asize = 1; d_addr = 32'h203; d_wdata = 32'h1234;
    #1;
    tests++;
    if ({bus_we, d_ready} !== 2'b00) begin fails++; $display("FAIL fault_idle: got we=%b rdy=%b want 0 0", bus_we, d_ready); end
    @(negedge clk);
    #1;
    tests++;
    if ({d_ready, d_err, i_ready, bus_we, bus_re} !== 5'b11000) begin
      fails++; $display("FAIL fault_cycle: got d_rdy=%b d_err=%b i_rdy=%b we=%b want 1 1 0 0", d_ready, d_err, i_ready, bus_we);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests++;
    if ({d_ready, d_err, bus_we} !== 3'b000) begin
      fails++; $display("FAIL fault_after: got rdy=%b err=%b we=%b want 0", d_ready, d_err, bus_we);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    d_re = 1; d_asize = 2; d_addr = 32'h40;
    #1;
    tests++;
    if (bus_re !== 0) begin fails++; $display("FAIL to_idle: got bus_re=%b want 0", bus_re); end
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      #1;
      tests++;
      if ({bus_re, d_ready, d_err} !== 3'b100) begin
        fails++; $display("FAIL to_wait[%0d]: got re=%b rdy=%b err=%b want 1 0 0", k, bus_re, d_ready, d_err);
      end
    end
    @(negedge clk);
    #1;
    tests++;
    if ({bus_re, d_ready, d_err} !== 3'b011) begin
      fails++; $display("FAIL to_fault: got re=%b rdy=%b err=%b want 0 1 1", bus_re, d_ready, d_err);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests++;
    if ({bus_re, d_ready, d_err} !== 3'b000) begin
      fails++; $display("FAIL to_after: got re=%b rdy=%b err=%b want 0", bus_re, d_ready, d_err);
    end
  endtask

  task automatic test_abort();
    do_reset();
    @(negedge clk);
    d_re = 1; d_asize = 2; d_addr = 32'h80; i_re = 1; i_addr = 32'h90;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) d_re = 0;
      #1;
      tests++;
      if ({bus_re, bus_addr, d_ready} !== (k == 2 ? 34'd0 : {1'b1, 32'h80, 1'b0})) begin
        fails++; $display("FAIL abort[%0d]: got re=%b addr=%h rdy=%b", k, bus_re, bus_addr, d_ready);
      end
    end
    @(negedge clk);
    #1;
    tests++;
    if ({bus_re, d_ready, i_ready} !== 3'b000) begin
      fails++; $display("FAIL abort_idle: got re=%b d_rdy=%b i_rdy=%b want 0", bus_re, d_ready, i_ready);
    end
    @(negedge clk);
    bus_ready = 1; bus_rdata = 32'h77;
    #1;
    tests++;
    if ({bus_re, bus_addr, i_ready, i_rdata, d_ready} !== {1'b1, 32'h90, 1'b1, 32'h77, 1'b0}) begin
      fails++; $display("FAIL abort_next: got re=%b addr=%h i_rdy=%b want 1 00000090 1", bus_re, bus_addr, i_ready);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_re = 1; d_asize = 2; d_addr = 32'hc0; i_re = 1; i_addr = 32'hd0;
    @(negedge clk);
    #1;
    tests++;
    if ({bus_re, bus_addr} !== {1'b1, 32'hc0}) begin
      fails++; $display("FAIL rmid_grant: got re=%b addr=%h want 1 000000c0", bus_re, bus_addr);
    end
    #2 rst = 1;
    #1;
    tests++;
    if ({bus_re, bus_we, d_ready, d_err, i_ready} !== 5'b0) begin
      fails++; $display("FAIL rmid_drop: got re=%b we=%b d_rdy=%b want 0", bus_re, bus_we, d_ready);
    end
    @(negedge clk);
    rst = 0;
    #1;
    tests++;
    if (bus_re !== 0) begin fails++; $display("FAIL rmid_idle: got bus_re=%b want 0", bus_re); end
    @(negedge clk);
    bus_ready = 1;
    #1;
    tests++;
    if ({bus_re, bus_addr, d_ready} !== {1'b1, 32'hc0, 1'b1}) begin
      fails++; $display("FAIL rmid_regrant: got re=%b addr=%h d_rdy=%b want data first", bus_re, bus_addr, d_ready);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    bit lg_d, ir, win_d, legal, drop, rdy;
    int dm, lat, ab;
    logic [35:0] exp_bus;
    do_reset();
    lg_d = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      ir = 1'($urandom_range(0, 1));
      dm = $urandom_range(0, 7);
      d_re = dm == 1 || dm == 2 || dm == 7;
      d_we = dm == 3 || dm == 4 || dm == 7;
      if (!ir && !d_re && !d_we) ir = 1;
      i_re = ir;
      i_addr = $urandom;
      if ($urandom_range(0, 4) != 0) i_addr[1:0] = 0;
      d_asize = 2'($urandom_range(0, 3));
      d_addr = $urandom;
      if ($urandom_range(0, 1) != 0) d_addr[1:0] = 0;
      d_wdata = $urandom;
      bus_rdata = $urandom;
      bus_ready = 1'($urandom_range(0, 1));
      #1;
      tests++;
      if ({bus_re, bus_we, i_ready, d_ready, i_rdata, d_rdata} !== '0) begin
        fails++; $display("FAIL rnd_idle[%0d]: got re=%b we=%b i_rdy=%b d_rdy=%b", n, bus_re, bus_we, i_ready, d_ready);
      end
      win_d = (d_re || d_we) && (!ir || !lg_d);
      legal = win_d ? !(d_re && d_we) && d_asize != 3 && (d_addr % (32'd1 << d_asize)) == 0 : i_addr % 4 == 0;
      exp_bus = win_d ? {d_re, d_we, d_asize, d_addr} : {1'b1, 1'b0, 2'd2, i_addr};
      if (!legal) begin
        @(negedge clk);
        bus_ready = 1'($urandom_range(0, 1));
        #1;
        tests++;
        if ({i_ready, i_err, d_ready, d_err, bus_re, bus_we} !== (win_d ? 6'b001100 : 6'b110000)) begin
          fails++; $display("FAIL rnd_fault[%0d]: got i=%b%b d=%b%b re=%b we=%b win_d=%b", n, i_ready, i_err, d_ready, d_err, bus_re, bus_we, win_d);
        end
        lg_d = win_d;
      end else begin
        lat = $urandom_range(0, 6);
        ab = (lat > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, (lat < TO ? lat : TO) - 1) : -1;
        for (int k = 0; k < TO; k++) begin
          @(negedge clk);
          drop = k == ab;
          if (drop && win_d) begin d_re = 0; d_we = 0; end
          if (drop && !win_d) i_re = 0;
          rdy = k == lat && !drop;
          bus_ready = rdy;
          bus_rdata = $urandom;
          #1;
          tests++;
          if ({bus_re, bus_we, bus_asize, bus_addr} !== (drop ? 36'd0 : exp_bus)) begin
            fails++; $display("FAIL rnd_bus[%0d.%0d]: got %h want %h", n, k, {bus_re, bus_we, bus_asize, bus_addr}, drop ? 36'd0 : exp_bus);
          end
          tests++;
          if (win_d && !drop && bus_wdata !== d_wdata) begin
            fails++; $display("FAIL rnd_wdata[%0d.%0d]: got %h want %h", n, k, bus_wdata, d_wdata);
          end
          tests++;
          if ({i_ready, i_err, d_ready, d_err} !== {!win_d && rdy, 1'b0, win_d && rdy, 1'b0}) begin
            fails++; $display("FAIL rnd_ready[%0d.%0d]: got i=%b%b d=%b%b want rdy=%b win_d=%b", n, k, i_ready, i_err, d_ready, d_err, rdy, win_d);
          end
          tests++;
          if ((win_d ? i_rdata : d_rdata) !== 0 || (!drop && (win_d ? d_rdata : i_rdata) !== bus_rdata)) begin
            fails++; $display("FAIL rnd_rdata[%0d.%0d]: got i=%h d=%h want %h on winner", n, k, i_rdata, d_rdata, bus_rdata);
          end
          if (rdy) lg_d = win_d;
          if (drop || rdy) break;
          if (k == TO - 1) begin
            @(negedge clk);
            bus_ready = 0;
            #1;
            tests++;
            if ({i_ready, i_err, d_ready, d_err, bus_re, bus_we} !== (win_d ? 6'b001100 : 6'b110000)) begin
              fails++; $display("FAIL rnd_timeout[%0d]: got i=%b%b d=%b%b re=%b win_d=%b", n, i_ready, i_err, d_ready, d_err, bus_re, win_d);
            end
            lg_d = win_d;
          end
        end
      end
      @(negedge clk);
      idle_inputs();
      bus_rdata = $urandom;
      #1;
      tests++;
      if ({bus_re, bus_we, i_ready, d_ready, i_err, d_err, i_rdata, d_rdata} !== '0) begin
        fails++; $display("FAIL rnd_after[%0d]: got re=%b i_rdy=%b d_rdy=%b", n, bus_re, i_ready, d_ready);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_lone_fetch();
    test_back_to_back();
    test_fault();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
